collide_scanner: RTL
====================

Name: collide_scanner

Overview:
- Sequential front end for the rectangle-overlap comparator.
- On each `start` pulse (once per frame), it reads an object table slot by slot, drives the comparator with the latched player box and each object box, and samples the comparator result.
- It publishes a stable per-object hit mask, an any-hit flag and the index of the first hit.
- Sits between the object table and the game-logic FSM.

Parameters:
- N_OBJ, 8, number of object-table slots scanned (2..256)
- IDX_W, 3, width of slot index; must satisfy 2^IDX_W >= N_OBJ
- CW, 9, coordinate/size width; matches the comparator

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  one-cycle scan request; honoured only in IDLE
- ply_x  input  CW  player box left edge
- ply_y  input  CW  player box top edge
- ply_w  input  CW  player box width
- ply_h  input  CW  player box height
- obj_addr  output  IDX_W  object table read address
- obj_x  input  CW  table data: object x, valid 1 cycle after obj_addr
- obj_y  input  CW  table data: object y, same timing
- obj_w  input  CW  table data: object width, same timing
- obj_h  input  CW  table data: object height, same timing
- obj_alive  input  1  table data: slot occupied, same timing
- cmp_en  output  1  comparator enable
- cmp_x1, cmp_y1, cmp_w1, cmp_h1  output  CW each  comparator box 1 (latched player)
- cmp_x2, cmp_y2, cmp_w2, cmp_h2  output  CW each  comparator box 2 (current object)
- cmp_hit  input  1  comparator result, combinational from cmp_* outputs
- busy  output  1  scan in progress (state != IDLE)
- done  output  1  one-cycle pulse: results updated
- hit_mask  output  N_OBJ  bit i = slot i overlapped in the last completed scan
- any_hit  output  1  OR of hit_mask
- first_hit  output  IDX_W  lowest set index of hit_mask; 0 when none

Behaviour:
- Reset (rst_n low, asynchronous) forces the following, all taking effect immediately regardless of clk:
  - state = IDLE
  - idx = 0, obj_addr = 0
  - cmp_en = 0
  - cmp_* = 0
  - scratch mask = 0
  - hit_mask = 0
  - any_hit = 0
  - first_hit = 0
  - busy = 0
  - done = 0
- Reset mid-scan discards the partial scan; no done pulse is produced.
- The state machine has four states: IDLE, FETCH, COMPARE, DONE.
- IDLE:
  - If start = 1 at a clock edge: latch ply_* into player registers, idx <= 0, scratch <= 0, go to FETCH.
  - start while not IDLE is ignored (no queueing).
- FETCH:
  - obj_addr = idx.
  - Go to COMPARE next edge.
- COMPARE:
  - Table data for idx is valid.
  - cmp_x1..h1 = latched player; cmp_x2..h2 = obj_*; cmp_en = obj_alive.
  - At the edge: scratch[idx] <= cmp_hit & obj_alive.
  - If idx == N_OBJ-1: go to DONE. Else idx <= idx+1 and go to FETCH.
- DONE:
  - hit_mask, any_hit and first_hit are updated at the edge entering DONE, from the final scratch (including the last slot's bit).
  - done = 1 for exactly this one cycle; go to IDLE next edge.
  - start during DONE is ignored.
- Outside COMPARE: cmp_en = 0 and cmp_* hold their last values; the comparator output is then don't-care and is never sampled.
- hit_mask, any_hit and first_hit are stable between done pulses. Software reads them any time.
- Latency: start sampled at edge E0; done is high in the cycle after edge E(2·N_OBJ), i.e. 2·N_OBJ+1 cycles from start edge to done. busy is high for the same 2·N_OBJ+1 cycles.
- Player inputs may change during the scan without effect; only the latched copy is used.
- Index arithmetic: idx never exceeds N_OBJ-1; no wrap occurs because the scan terminates at N_OBJ-1.
- first_hit: priority encode of the final mask, lowest index wins.

Test Plan:
- Reset/idle:
  - Stimulus: assert rst_n=0 mid-operation, release, no start.
  - Required response: all outputs 0; busy=0; done never pulses.
- Single hit, N_OBJ=8:
  - Stimulus: player (10,10,16,16). Slot 3 = (20,20,8,8) alive; all other slots alive at (200,200,8,8). Pulse start.
  - Required response: done exactly 17 cycles after start edge; hit_mask=8'b0000_1000; any_hit=1; first_hit=3.
- Dead slot and edge touch:
  - Stimulus: slot 0 overlaps the player but obj_alive=0. Slot 5 = (26,10,8,8), touching the right edge only.
  - Required response: hit_mask=0; any_hit=0; first_hit=0; cmp_en low during the slot 0 COMPARE.
- Multiple hits:
  - Stimulus: slots 1, 4 and 7 overlap.
  - Required response: hit_mask=8'b1001_0010; first_hit=1; the previous hit_mask is held until the done cycle.
- start while busy:
  - Stimulus: pulse start at cycles 0, 5 and 17 (the DONE cycle).
  - Required response: exactly one scan; done once; busy drops after cycle 17. A start at cycle 18 launches a new scan.
- Reset mid-scan and player change:
  - Stimulus: ply_x changes at cycle 4. Separately, rst_n pulsed low at cycle 9.
  - Required response: the ply_x change does not alter the result. After the reset pulse: no done, all outputs 0, and a subsequent start scans normally.

Source files
------------

// File: rtl/collide_scanner_if.sv
// Signal bundle between the collide scanner, its object table, the overlap
// comparator and the game-logic FSM. slave = scanner side, master = environment.
interface collide_scanner_if #(
  parameter int N_OBJ = 8,
  parameter int IDX_W = 3,
  parameter int CW    = 9
);
  logic             start;
  logic [CW-1:0]    ply_x;
  logic [CW-1:0]    ply_y;
  logic [CW-1:0]    ply_w;
  logic [CW-1:0]    ply_h;

  logic [IDX_W-1:0] obj_addr;
  logic [CW-1:0]    obj_x;
  logic [CW-1:0]    obj_y;
  logic [CW-1:0]    obj_w;
  logic [CW-1:0]    obj_h;
  logic             obj_alive;

  logic             cmp_en;
  logic [CW-1:0]    cmp_x1;
  logic [CW-1:0]    cmp_y1;
  logic [CW-1:0]    cmp_w1;
  logic [CW-1:0]    cmp_h1;
  logic [CW-1:0]    cmp_x2;
  logic [CW-1:0]    cmp_y2;
  logic [CW-1:0]    cmp_w2;
  logic [CW-1:0]    cmp_h2;
  logic             cmp_hit;

  logic             busy;
  logic             done;
  logic [N_OBJ-1:0] hit_mask;
  logic             any_hit;
  logic [IDX_W-1:0] first_hit;

  modport slave (
    input  start, ply_x, ply_y, ply_w, ply_h,
    input  obj_x, obj_y, obj_w, obj_h, obj_alive,
    input  cmp_hit,
    output obj_addr,
    output cmp_en, cmp_x1, cmp_y1, cmp_w1, cmp_h1, cmp_x2, cmp_y2, cmp_w2, cmp_h2,
    output busy, done, hit_mask, any_hit, first_hit
  );

  modport master (
    output start, ply_x, ply_y, ply_w, ply_h,
    output obj_x, obj_y, obj_w, obj_h, obj_alive,
    output cmp_hit,
    input  obj_addr,
    input  cmp_en, cmp_x1, cmp_y1, cmp_w1, cmp_h1, cmp_x2, cmp_y2, cmp_w2, cmp_h2,
    input  busy, done, hit_mask, any_hit, first_hit
  );
endinterface

// File: rtl/collide_scanner.sv
// Per-frame scan of the object table against the latched player box through an
// external overlap comparator; publishes hit mask, any-hit and first-hit index.
//
// state   | meaning
// IDLE    | waiting for start; results held
// FETCH   | obj_addr = idx, table read in flight
// COMPARE | table data valid, comparator driven, hit bit sampled
// DONE    | results published, done pulse
module collide_scanner #(
  parameter int N_OBJ = 8,
  parameter int IDX_W = 3,
  parameter int CW    = 9
) (
  input  logic              clk,
  input  logic              rst_n,
  collide_scanner_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, FETCH, COMPARE, DONE} state_t;

  localparam logic [IDX_W-1:0] LAST = IDX_W'(N_OBJ - 1);

  state_t           state, state_nxt;
  logic [IDX_W-1:0] idx, idx_nxt;
  logic [N_OBJ-1:0] scratch, scratch_nxt;

  logic [CW-1:0]    px, py, pw, ph;
  logic [CW-1:0]    hx1, hy1, hw1, hh1;
  logic [CW-1:0]    hx2, hy2, hw2, hh2;

  logic [N_OBJ-1:0] hit_mask_q;
  logic             any_hit_q;
  logic [IDX_W-1:0] first_hit_q;
  logic [IDX_W-1:0] first_nxt;

  logic             in_cmp;
  logic             last_slot;

  assign in_cmp    = (state == COMPARE);
  assign last_slot = (idx == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    idx_nxt     = idx;
    scratch_nxt = scratch;
    case (state)
      IDLE: begin
        if (bus.start) begin
          idx_nxt     = '0;
          scratch_nxt = '0;
          state_nxt   = FETCH;
        end
      end
      FETCH: state_nxt = COMPARE;
      COMPARE: begin
        scratch_nxt[idx] = bus.cmp_hit & bus.obj_alive;
        if (last_slot) begin
          state_nxt = DONE;
        end else begin
          idx_nxt   = idx + 1'b1;
          state_nxt = FETCH;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // lowest set bit of the mask being published wins
  always_comb begin
    first_nxt = '0;
    for (int i = N_OBJ - 1; i >= 0; i--) begin
      if (scratch_nxt[i]) first_nxt = IDX_W'(i);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx     <= '0;
      scratch <= '0;
      px      <= '0;
      py      <= '0;
      pw      <= '0;
      ph      <= '0;
    end else begin
      idx     <= idx_nxt;
      scratch <= scratch_nxt;
      if (state == IDLE && bus.start) begin
        px <= bus.ply_x;
        py <= bus.ply_y;
        pw <= bus.ply_w;
        ph <= bus.ply_h;
      end
    end
  end

  // last driven comparator boxes, so cmp_* hold between COMPARE cycles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hx1 <= '0;
      hy1 <= '0;
      hw1 <= '0;
      hh1 <= '0;
      hx2 <= '0;
      hy2 <= '0;
      hw2 <= '0;
      hh2 <= '0;
    end else if (in_cmp) begin
      hx1 <= px;
      hy1 <= py;
      hw1 <= pw;
      hh1 <= ph;
      hx2 <= bus.obj_x;
      hy2 <= bus.obj_y;
      hw2 <= bus.obj_w;
      hh2 <= bus.obj_h;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_mask_q  <= '0;
      any_hit_q   <= 1'b0;
      first_hit_q <= '0;
    end else if (in_cmp && last_slot) begin
      hit_mask_q  <= scratch_nxt;
      any_hit_q   <= |scratch_nxt;
      first_hit_q <= first_nxt;
    end
  end

  assign bus.obj_addr  = idx;
  assign bus.cmp_en    = in_cmp & bus.obj_alive;
  assign bus.cmp_x1    = in_cmp ? px        : hx1;
  assign bus.cmp_y1    = in_cmp ? py        : hy1;
  assign bus.cmp_w1    = in_cmp ? pw        : hw1;
  assign bus.cmp_h1    = in_cmp ? ph        : hh1;
  assign bus.cmp_x2    = in_cmp ? bus.obj_x : hx2;
  assign bus.cmp_y2    = in_cmp ? bus.obj_y : hy2;
  assign bus.cmp_w2    = in_cmp ? bus.obj_w : hw2;
  assign bus.cmp_h2    = in_cmp ? bus.obj_h : hh2;

  assign bus.busy      = (state != IDLE);
  assign bus.done      = (state == DONE);
  assign bus.hit_mask  = hit_mask_q;
  assign bus.any_hit   = any_hit_q;
  assign bus.first_hit = first_hit_q;

endmodule
